// File: rtl/o_buft_arbiter.sv
// Round-robin arbiter sharing one O_BUFT pad among NUM_REQ requesters, with turnaround gaps.
// Latency: grant, data and release all registered, one cycle after the sampling edge.
// Backpressure: owners hold the pad until they drop REQ, or until MAX_BURST is reached while others wait.
module o_buft_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int TURNAROUND = 1,
    parameter int MAX_BURST  = 16,
    localparam int OW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_REQ-1:0] REQ,
    input  logic [NUM_REQ-1:0] DATA,
    output logic [NUM_REQ-1:0] GNT,
    output logic [OW-1:0]      OWNER,
    output logic               BUF_I,
    output logic               BUF_T,
    output logic               BUSY
);

    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $fatal(1, "o_buft_arbiter: NUM_REQ must be 2..16");
    end
    if (TURNAROUND < 0 || TURNAROUND > 15) begin : g_bad_turnaround
        $fatal(1, "o_buft_arbiter: TURNAROUND must be 0..15");
    end
    if (MAX_BURST < 0 || MAX_BURST > 255) begin : g_bad_max_burst
        $fatal(1, "o_buft_arbiter: MAX_BURST must be 0..255");
    end

    localparam logic [7:0] MB8 = 8'(MAX_BURST);
    localparam logic [3:0] TA4 = 4'(TURNAROUND);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t               state;
    logic [7:0]           burst_cnt;
    logic [3:0]           turn_cnt;
    logic                 win_vld;
    logic [OW-1:0]        win_idx;
    logic [NUM_REQ-1:0]   win_oh;
    logic [NUM_REQ-1:0]   own_mask;
    logic                 others_req;
    logic                 rel_now;
    logic                 take;

    // Walk from OWNER+NUM_REQ down to OWNER+1 so the nearest requester after OWNER wins.
    always_comb begin
        int idx;
        idx     = 0;
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(OWNER) + k) % NUM_REQ;
            if (REQ[idx]) begin
                win_vld = 1'b1;
                win_idx = OW'(idx);
            end
        end
        win_oh          = '0;
        win_oh[win_idx] = 1'b1;
    end

    always_comb begin
        own_mask        = '0;
        own_mask[OWNER] = 1'b1;
        others_req      = |(REQ & ~own_mask);
        rel_now         = !REQ[OWNER] ||
                          ((MAX_BURST != 0) && (burst_cnt >= MB8) && others_req);
        take            = win_vld && ((state == IDLE) ||
                          (state == OWNED && rel_now && TURNAROUND == 0) ||
                          (state == TURN && turn_cnt >= TA4));
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            GNT       <= '0;
            OWNER     <= OW'(NUM_REQ - 1);
            BUF_I     <= 1'b0;
            BUF_T     <= 1'b0;
            burst_cnt <= '0;
            turn_cnt  <= '0;
        end else if (take) begin
            state     <= OWNED;
            GNT       <= win_oh;
            OWNER     <= win_idx;
            BUF_T     <= 1'b1;
            BUF_I     <= DATA[win_idx];
            burst_cnt <= 8'd1;
            turn_cnt  <= '0;
        end else begin
            case (state)
                IDLE: ;
                OWNED: begin
                    if (!rel_now) begin
                        BUF_I <= DATA[OWNER];
                        if (burst_cnt != 8'hFF) burst_cnt <= burst_cnt + 8'd1;
                    end else begin
                        GNT       <= '0;
                        BUF_T     <= 1'b0;
                        BUF_I     <= 1'b0;
                        burst_cnt <= '0;
                        if (TA4 == 4'd0) begin
                            state <= IDLE;
                        end else begin
                            state    <= TURN;
                            turn_cnt <= 4'd1;
                        end
                    end
                end
                TURN: begin
                    if (turn_cnt < TA4) begin
                        turn_cnt <= turn_cnt + 4'd1;
                    end else begin
                        turn_cnt <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign BUSY = (state != IDLE);

endmodule
